// File: rtl/arp_pkg.sv
// arp_pkg: ARP field constants and reply-encoder state type.
// ARP_PAD_EN adds the PAD state used to stretch the reply to the minimum Ethernet payload.
package arp_pkg;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN       = 8'd6;
    localparam logic [7:0]  ARP_PLEN       = 8'd4;
    localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;
    localparam int          ARP_LEN        = 28;
    localparam int          ARP_PAD_LEN    = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
`ifdef ARP_PAD_EN
        ST_PAD,
`endif
        ST_SEND
    } arp_state_t;
endpackage

// File: rtl/arp_reply_encode.sv
// arp_reply_encode: serialises an ARP reply for an accepted request addressed to LOCAL_IP.
// Define ARP_PAD_EN to append 18 zero bytes (46-byte minimum Ethernet payload).
module arp_reply_encode
    import arp_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h665544332211,
    parameter logic [31:0] LOCAL_IP  = 32'h0A00A8C0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        req_err,
    input  logic [47:0] req_sha,
    input  logic [31:0] req_spa,
    input  logic [31:0] req_tpa,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy
);
    localparam logic [63:0] HDR = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN, ARP_OPER_REPLY};
`ifdef ARP_PAD_EN
    localparam logic [5:0] LAST_IDX = 6'(ARP_LEN + ARP_PAD_LEN - 1);
`else
    localparam logic [5:0] LAST_IDX = 6'(ARP_LEN - 1);
`endif

    arp_state_t  r_state;
    logic [5:0]  r_idx;
    logic [47:0] r_sha;
    logic [31:0] r_spa;
    logic        r_valid;
    logic        r_last;
    logic [7:0]  r_data;

    logic        w_accept;
    logic        w_xfer;
    logic [5:0]  w_sel;
    logic [63:0] w_hdr_sh;
    logic [47:0] w_mac_sh;
    logic [31:0] w_ip_sh;
    logic [47:0] w_sha_sh;
    logic [31:0] w_spa_sh;
    logic [7:0]  w_byte;

    assign w_accept = (r_state == ST_IDLE) && start && !req_err && (req_tpa == LOCAL_IP);
    assign w_xfer   = r_valid && out_ready;
    // Byte for the index being loaded next: 0 on acceptance, otherwise the one after the current.
    assign w_sel    = (r_state == ST_IDLE) ? 6'd0 : r_idx + 6'd1;
    assign w_hdr_sh = HDR >> {3'd7 - w_sel[2:0], 3'b000};
    assign w_mac_sh = LOCAL_MAC >> {w_sel - 6'd8, 3'b000};
    assign w_ip_sh  = LOCAL_IP >> {w_sel - 6'd14, 3'b000};
    assign w_sha_sh = r_sha >> {w_sel - 6'd18, 3'b000};
    assign w_spa_sh = r_spa >> {w_sel - 6'd24, 3'b000};
    // Acceptance feeds the byte-0 path, so latched fields are never needed before they are stored.
    assign w_byte   = (w_sel < 6'd8)  ? w_hdr_sh[7:0] :
                      (w_sel < 6'd14) ? w_mac_sh[7:0] :
                      (w_sel < 6'd18) ? w_ip_sh[7:0]  :
                      (w_sel < 6'd24) ? w_sha_sh[7:0] :
                      (w_sel < 6'd28) ? w_spa_sh[7:0] : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_sha   <= '0;
            r_spa   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_state <= ST_SEND;
            r_idx   <= '0;
            r_sha   <= req_sha;
            r_spa   <= req_spa;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_data  <= w_byte;
        end else if (w_xfer) begin
            if (r_last) begin
                r_state <= ST_IDLE;
                r_idx   <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_data  <= '0;
            end else begin
                r_idx   <= w_sel;
                r_data  <= w_byte;
                r_last  <= (w_sel == LAST_IDX);
`ifdef ARP_PAD_EN
                r_state <= (w_sel >= 6'(ARP_LEN)) ? ST_PAD : ST_SEND;
`endif
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = r_valid;
endmodule

// File: tb/tb_arp_reply_encode.sv
// tb_arp_reply_encode: directed plus random checks of the ARP reply stream against a byte-list model.
module tb_arp_reply_encode;
    import arp_pkg::*;

    localparam logic [47:0] MAC = 48'h665544332211;
    localparam logic [31:0] IP  = 32'h0A00A8C0;
`ifdef ARP_PAD_EN
    localparam int N = 46;
`else
    localparam int N = 28;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        req_err = 1'b0;
    logic [47:0] req_sha = '0;
    logic [31:0] req_spa = '0;
    logic [31:0] req_tpa = '0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    arp_reply_encode dut (
        .clk(clk), .rst(rst), .start(start), .req_err(req_err),
        .req_sha(req_sha), .req_spa(req_spa), .req_tpa(req_tpa),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void build(input logic [47:0] sha, input logic [31:0] spa);
        exp_q = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(MAC >> (8 * i)));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(IP >> (8 * i)));
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(sha >> (8 * i)));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(spa >> (8 * i)));
        while (exp_q.size() < N) exp_q.push_back(8'h00);
    endfunction

    task automatic do_start(input logic [47:0] sha, input logic [31:0] spa,
                            input logic [31:0] tpa, input logic err);
        @(negedge clk);
        start = 1'b1; req_sha = sha; req_spa = spa; req_tpa = tpa; req_err = err;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk({tag, "_valid"}, out_valid, 1'b0);
            chk({tag, "_busy"}, busy, 1'b0);
            @(negedge clk);
        end
    endtask

    // mode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready
    task automatic recv(input int mode, input int inject, input int abort);
        int k = 0;
        int cyc = 0;
        while (k < N && cyc < 2000) begin
            chk("valid", out_valid, 1'b1);
            chk("busy", busy, 1'b1);
            chk($sformatf("data[%0d]", k), out_data, exp_q[k]);
            chk($sformatf("last[%0d]", k), out_last, k == N - 1);
            if (k == abort) begin
                rst = 1'b0;
                #1;
                chk("rst_valid", out_valid, 1'b0);
                chk("rst_data", out_data, 8'h00);
                chk("rst_last", out_last, 1'b0);
                chk("rst_busy", busy, 1'b0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom % 2);
            start = (k == inject);
            req_sha = 48'h123456789ABC; req_spa = 32'h11111111; req_tpa = IP; req_err = 1'b0;
            @(negedge clk);
            start = 1'b0;
            if (out_ready) k++;
            cyc++;
        end
        chk("recv_timeout", k, N);
        out_ready = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_data", out_data, 8'h00);
        chk("reset_last", out_last, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b1;
        out_ready = 1'b1;

        build(48'hFFEEDDCCBBAA, 32'h0100A8C0);
        do_start(48'hFFEEDDCCBBAA, 32'h0100A8C0, IP, 1'b0);
        recv(0, -1, -1);
        idle_check("after_basic", 4);

        do_start(48'hFFEEDDCCBBAA, 32'h0100A8C0, 32'h0B00A8C0, 1'b0);
        idle_check("drop_tpa", 3);
        do_start(48'hFFEEDDCCBBAA, 32'h0100A8C0, IP, 1'b1);
        idle_check("drop_err", 3);

        do_start(48'hFFEEDDCCBBAA, 32'h0100A8C0, IP, 1'b0);
        recv(1, -1, -1);
        idle_check("after_stall", 3);

        do_start(48'hFFEEDDCCBBAA, 32'h0100A8C0, IP, 1'b0);
        recv(0, 10, -1);
        idle_check("after_restart", 4);

        do_start(48'hFFEEDDCCBBAA, 32'h0100A8C0, IP, 1'b0);
        recv(0, N - 1, -1);
        idle_check("after_final_start", 4);

        do_start(48'hFFEEDDCCBBAA, 32'h0100A8C0, IP, 1'b0);
        recv(0, -1, 15);
        idle_check("after_abort", 3);
        do_start(48'hFFEEDDCCBBAA, 32'h0100A8C0, IP, 1'b0);
        recv(0, -1, -1);
        idle_check("after_fresh", 3);

        for (int t = 0; t < 6; t++) begin
            logic [47:0] sha;
            logic [31:0] spa;
            sha = {16'($urandom), 32'($urandom)};
            spa = 32'($urandom);
            build(sha, spa);
            do_start(sha, spa, IP, 1'b0);
            recv(2, -1, -1);
            idle_check("after_random", 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
